// File: rtl/signed_accum_sat_pkg.sv
// Shared signed-arithmetic helpers for the saturating accumulator.
// Contents:
//   SAT_WRAP / SAT_CLAMP : sat_mode encodings (0 = wrap, 1 = clamp)
//   signed_max(w)        : 2^(w-1)-1 as a 64-bit pattern, truncate to w bits
//   signed_min(w)        : -2^(w-1) as a 64-bit pattern, truncate to w bits
package signed_arith_pkg;

  localparam logic SAT_WRAP  = 1'b0;
  localparam logic SAT_CLAMP = 1'b1;

  function automatic logic [63:0] signed_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Bitwise inverse of 0111..1 is 1000..0, the most negative value.
  function automatic logic [63:0] signed_min(input int w);
    return ~signed_max(w);
  endfunction

endpackage

// File: rtl/signed_accum_sat_if.sv
// Bus bundle for signed_accum_sat.
// Inputs to the accumulator : in_valid, in_data, clear, sat_mode
// Outputs from accumulator  : out_valid, acc, ovf, ovf_sticky, ovf_cnt
// master = the producer/consumer around the block, slave = the accumulator.
interface signed_accum_sat_if
  import signed_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             clear;
  logic             sat_mode;
  logic             out_valid;
  logic [WIDTH-1:0] acc;
  logic             ovf;
  logic             ovf_sticky;
  logic [CNT_W-1:0] ovf_cnt;

  modport master (
    output in_valid, in_data, clear, sat_mode,
    input  out_valid, acc, ovf, ovf_sticky, ovf_cnt
  );

  modport slave (
    input  in_valid, in_data, clear, sat_mode,
    output out_valid, acc, ovf, ovf_sticky, ovf_cnt
  );

endinterface

// File: rtl/signed_accum_sat_add.sv
// Combinational signed adder with overflow detect and optional clamp.
// Ports:
//   a, b : WIDTH-bit two's-complement operands
//   sat  : SAT_WRAP -> wrapped sum, SAT_CLAMP -> clamp on overflow
//   sum  : WIDTH-bit result
//   ovf  : operands share a sign and the WIDTH-bit result sign differs
module signed_add_sat_w
  import signed_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sat,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(signed_max(WIDTH));
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(signed_min(WIDTH));

  logic [WIDTH:0] full_sum;

  // The extra top bit of full_sum is the true sign of the exact result, so
  // it selects the clamp direction: set means the sum went below MIN_V.
  always_comb begin
    full_sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    ovf      = (a[WIDTH-1] == b[WIDTH-1]) && (full_sum[WIDTH-1] != a[WIDTH-1]);
    sum      = full_sum[WIDTH-1:0];
    if (ovf && (sat == SAT_CLAMP)) begin
      sum = full_sum[WIDTH] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/signed_accum_sat.sv
// Signed accumulator with wrap/clamp overflow handling and overflow stats.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears every output
//   bus   : slave side of signed_accum_sat_if
//           in_valid/in_data/sat_mode -> accumulate in_data onto acc
//           clear -> restart (acc = in_data if in_valid, else 0), drop stats
//           out_valid/ovf pulse one cycle per accepted input
//           ovf_sticky/ovf_cnt summarise overflows since reset or clear
module signed_accum_sat
  import signed_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic               clk,
  input logic               rst_n,
  signed_accum_sat_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;

  signed_add_sat_w #(.WIDTH(WIDTH)) u_add (
    .a   (acc_q),
    .b   (bus.in_data),
    .sat (bus.sat_mode),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // clear outranks accumulation; a clear with valid data seeds acc directly.
  always_comb begin
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    ovf_d       = 1'b0;
    sticky_d    = sticky_q;
    cnt_d       = cnt_q;
    if (bus.clear) begin
      acc_d       = bus.in_valid ? bus.in_data : '0;
      out_valid_d = bus.in_valid;
      sticky_d    = 1'b0;
      cnt_d       = '0;
    end else if (bus.in_valid) begin
      acc_d       = add_sum;
      out_valid_d = 1'b1;
      ovf_d       = add_ovf;
      if (add_ovf) begin
        sticky_d = 1'b1;
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.acc        = acc_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.ovf        = ovf_q;
  assign bus.ovf_sticky = sticky_q;
  assign bus.ovf_cnt    = cnt_q;

endmodule

// File: tb/tb_signed_accum_sat.sv
// Bench for signed_accum_sat: a WIDTH=4/CNT_W=2 instance driven from a
// vector table plus a mid-stream reset sequence, and a WIDTH=8/CNT_W=4
// instance driven by random traffic against an integer reference model.
module tb_signed_accum_sat;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  signed_accum_sat_if #(.WIDTH(4), .CNT_W(2)) if4 ();
  signed_accum_sat_if #(.WIDTH(8), .CNT_W(4)) if8 ();

  signed_accum_sat #(.WIDTH(4), .CNT_W(2)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4)
  );

  signed_accum_sat #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic       clr;
    logic       sat;
    logic [3:0] d;
    logic [3:0] e_acc;
    logic       e_ovf;
    logic       e_st;
    logic [1:0] e_cnt;
    logic       e_ov;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic v, input logic clr, input logic sat,
                              input logic [3:0] d, input logic [3:0] e_acc,
                              input logic e_ovf, input logic e_st,
                              input logic [1:0] e_cnt, input logic e_ov);
    vec_t r;
    r.v = v; r.clr = clr; r.sat = sat; r.d = d;
    r.e_acc = e_acc; r.e_ovf = e_ovf; r.e_st = e_st; r.e_cnt = e_cnt; r.e_ov = e_ov;
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic clr, input logic sat,
                               input logic [3:0] d);
    if4.in_valid = v;
    if4.clear    = clr;
    if4.sat_mode = sat;
    if4.in_data  = d;
  endtask

  task automatic check4(input string tag, input int e_acc, input int e_ovf,
                        input int e_st, input int e_cnt, input int e_ov);
    checkOutput({tag, " acc"},        int'(if4.acc),        e_acc);
    checkOutput({tag, " ovf"},        int'(if4.ovf),        e_ovf);
    checkOutput({tag, " ovf_sticky"}, int'(if4.ovf_sticky), e_st);
    checkOutput({tag, " ovf_cnt"},    int'(if4.ovf_cnt),    e_cnt);
    checkOutput({tag, " out_valid"},  int'(if4.out_valid),  e_ov);
  endtask

  // Reference model for the 8-bit instance, plain integer arithmetic.
  int m_acc, m_cnt, m_sticky, m_ovf, m_ov;

  task automatic model_step(input bit v, input bit clr, input bit sat, input int sd);
    int s;
    if (clr) begin
      m_acc = v ? sd : 0;
      m_cnt = 0; m_sticky = 0; m_ovf = 0; m_ov = v ? 1 : 0;
    end else if (v) begin
      s     = m_acc + sd;
      m_ov  = 1;
      m_ovf = (s > 127 || s < -128) ? 1 : 0;
      if (m_ovf != 0) begin
        m_sticky = 1;
        if (m_cnt < 15) m_cnt = m_cnt + 1;
        if (sat) s = (s > 127) ? 127 : -128;
        else if (s > 127) s = s - 256;
        else s = s + 256;
      end
      m_acc = s;
    end else begin
      m_ov = 0; m_ovf = 0;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);
    if8.in_valid = 1'b0; if8.clear = 1'b0; if8.sat_mode = 1'b0; if8.in_data = 8'h00;
    m_acc = 0; m_cnt = 0; m_sticky = 0; m_ovf = 0; m_ov = 0;

    // Wrap-mode overflow, clamp-mode overflow, count saturation, clear+valid.
    vecs[0]  = mk(0, 1, 0, 4'h0, 4'h0, 0, 0, 2'd0, 0);
    vecs[1]  = mk(1, 0, 0, 4'h7, 4'h7, 0, 0, 2'd0, 1);
    vecs[2]  = mk(1, 0, 0, 4'h1, 4'h8, 1, 1, 2'd1, 1);
    vecs[3]  = mk(0, 0, 0, 4'h5, 4'h8, 0, 1, 2'd1, 0);
    vecs[4]  = mk(0, 1, 0, 4'h0, 4'h0, 0, 0, 2'd0, 0);
    vecs[5]  = mk(1, 0, 1, 4'h8, 4'h8, 0, 0, 2'd0, 1);
    vecs[6]  = mk(1, 0, 1, 4'hF, 4'h8, 1, 1, 2'd1, 1);
    vecs[7]  = mk(1, 0, 1, 4'h3, 4'hB, 0, 1, 2'd1, 1);
    vecs[8]  = mk(0, 1, 0, 4'h0, 4'h0, 0, 0, 2'd0, 0);
    vecs[9]  = mk(1, 0, 0, 4'h7, 4'h7, 0, 0, 2'd0, 1);
    vecs[10] = mk(1, 0, 0, 4'h1, 4'h8, 1, 1, 2'd1, 1);
    vecs[11] = mk(1, 0, 0, 4'hF, 4'h7, 1, 1, 2'd2, 1);
    vecs[12] = mk(1, 0, 0, 4'h1, 4'h8, 1, 1, 2'd3, 1);
    vecs[13] = mk(1, 0, 0, 4'hF, 4'h7, 1, 1, 2'd3, 1);
    vecs[14] = mk(1, 0, 0, 4'h1, 4'h8, 1, 1, 2'd3, 1);
    vecs[15] = mk(1, 1, 0, 4'h5, 4'h5, 0, 0, 2'd0, 1);
    vecs[16] = mk(1, 0, 0, 4'h2, 4'h7, 0, 0, 2'd0, 1);

    #2;
    check4("reset4", 0, 0, 0, 0, 0);
    checkOutput("reset8 acc", int'(if8.acc), 0);
    checkOutput("reset8 out_valid", int'(if8.out_valid), 0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].v, vecs[i].clr, vecs[i].sat, vecs[i].d);
      @(posedge clk);
      #1;
      check4($sformatf("vec%0d", i), int'(vecs[i].e_acc), int'(vecs[i].e_ovf),
             int'(vecs[i].e_st), int'(vecs[i].e_cnt), int'(vecs[i].e_ov));
    end

    // Mid-stream asynchronous reset: 7 + 3 overflows, then reset between edges.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 4'h3);
    @(posedge clk);
    #1;
    check4("prereset", 4'hA, 1, 1, 1, 1);
    #1;
    if4.in_data = 4'h2;
    rst_n = 1'b0;
    #1;
    check4("async_reset", 0, 0, 0, 0, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check4("post_reset", 2, 0, 0, 0, 1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0);

    // Randomised 8-bit stream against the integer model.
    for (int n = 0; n < 400; n++) begin
      bit v, clr, sat;
      logic [7:0] d;
      @(negedge clk);
      v   = ($urandom_range(0, 9) < 8);
      clr = ($urandom_range(0, 31) == 0);
      sat = $urandom_range(0, 1) == 1;
      d   = 8'($urandom);
      if8.in_valid = v; if8.clear = clr; if8.sat_mode = sat; if8.in_data = d;
      @(posedge clk);
      #1;
      model_step(v, clr, sat, int'($signed(d)));
      checkOutput($sformatf("rnd%0d acc", n), int'($signed(if8.acc)), m_acc);
      checkOutput($sformatf("rnd%0d ovf", n), int'(if8.ovf), m_ovf);
      checkOutput($sformatf("rnd%0d ovf_cnt", n), int'(if8.ovf_cnt), m_cnt);
      checkOutput($sformatf("rnd%0d ovf_sticky", n), int'(if8.ovf_sticky), m_sticky);
      checkOutput($sformatf("rnd%0d out_valid", n), int'(if8.out_valid), m_ov);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
